count_seek_ctrl: RTL and testbench

//   Command-side driver for the up/down counter (counter_struct): drives its count_up/count_down inputs
//   and reads back cnt, stepping the counter one unit at a time until cnt equals a requested target.

---
 rtl/count_seek_ctrl_if.sv | 18 +
 rtl/count_seek_ctrl.sv | 120 ++++++++++++
 tb/tb_count_seek_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/count_seek_ctrl_if.sv
// Command-side bundle for count_seek_ctrl.
//   master : requester (ALU control FSM) - drives start/abort/target, reads status
//   slave  : count_seek_ctrl            - reads request, drives busy/done/err/steps
interface count_seek_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int SW    = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] target;
  logic             busy;
  logic             done;
  logic             err;
  logic [SW-1:0]    steps;

  modport master (output start, abort, target, input busy, done, err, steps);
  modport slave  (input start, abort, target, output busy, done, err, steps);
endinterface

// File: rtl/count_seek_ctrl.sv
// count_seek_ctrl: steps an external up/down counter one unit at a time until
// its value equals a requested target, with step limit, abort and optional
// shortest-path (modulo) direction selection.
// Ports:
//   clk        rising-edge clock shared with the counter
//   reset      asynchronous active-low reset
//   cmd        request/status bundle (start, abort, target / busy, done, err, steps)
//   cnt        counter value fed back from the counter
//   count_up   one-cycle increment pulse to the counter
//   count_down one-cycle decrement pulse to the counter
module count_seek_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_STEPS = 15,
  parameter int SHORTEST  = 0,
  parameter int SW        = 4
) (
  input  logic                clk,
  input  logic                reset,
  count_seek_ctrl_if.slave    cmd,
  input  logic [WIDTH-1:0]    cnt,
  output logic                count_up,
  output logic                count_down
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_STEP,
    S_WAIT,
    S_FINISH
  } state_t;

  localparam logic [WIDTH-1:0] HALF  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SW-1:0]    MAX_Q = SW'(MAX_STEPS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             dir_up_q, dir_up_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] diff;
  logic             up_pref;

  // Direction preference for the current cnt/tgt pair. In modulo mode the
  // forward distance decides; exactly half-way counts as up.
  always_comb begin
    diff = tgt_q - cnt;
    if (SHORTEST != 0) up_pref = (diff <= HALF);
    else               up_pref = (tgt_q > cnt);
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    dir_up_d = dir_up_q;
    steps_d  = steps_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.start) begin
          tgt_d   = cmd.target;
          steps_d = '0;
          err_d   = 1'b0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (cmd.abort)         state_d = S_IDLE;
        else if (cnt == tgt_q) state_d = S_FINISH;
        else begin
          dir_up_d = up_pref;
          state_d  = S_STEP;
        end
      end
      S_STEP: begin
        // The pulse is already on the wire this cycle, so it is counted even
        // when the seek is being aborted.
        steps_d = steps_q + SW'(1);
        state_d = cmd.abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (cmd.abort)              state_d = S_IDLE;
        else if (cnt == tgt_q)      state_d = S_FINISH;
        else if (steps_q == MAX_Q) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
        else                        state_d = S_STEP;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      dir_up_q <= 1'b0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      dir_up_q <= dir_up_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode from registered state only.
  assign count_up   = (state_q == S_STEP) &&  dir_up_q;
  assign count_down = (state_q == S_STEP) && !dir_up_q;
  assign cmd.busy   = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign cmd.done   = (state_q == S_FINISH);
  assign cmd.err    = err_q;
  assign cmd.steps  = steps_q;

endmodule

// File: tb/tb_count_seek_ctrl.sv
module tb_count_seek_ctrl;

  localparam int SH [3] = '{0, 1, 0};
  localparam int MX [3] = '{15, 15, 4};

  typedef struct {
    int unsigned cnt;
    int unsigned steps;
    int unsigned err;
    int unsigned ups;
    int unsigned dns;
    int unsigned lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [3:0] target;
  logic       load;
  logic [3:0] load_val;

  logic [2:0] busy_v, done_v, err_v, up_v, dn_v;
  logic [3:0] steps_v [3];
  logic [3:0] cnt_v [3];

  int unsigned compared = 0, mismatched = 0;
  int unsigned edge_n = 0, start_edge = 0;
  int unsigned ups_n [3], dns_n [3], both_n [3];
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  count_seek_ctrl_if #(.WIDTH(4), .SW(4)) bus0 ();
  count_seek_ctrl_if #(.WIDTH(4), .SW(4)) bus1 ();
  count_seek_ctrl_if #(.WIDTH(4), .SW(4)) bus2 ();

  assign bus0.start = start;  assign bus0.abort = abort;  assign bus0.target = target;
  assign bus1.start = start;  assign bus1.abort = abort;  assign bus1.target = target;
  assign bus2.start = start;  assign bus2.abort = abort;  assign bus2.target = target;
  assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
  assign done_v = {bus2.done, bus1.done, bus0.done};
  assign err_v  = {bus2.err,  bus1.err,  bus0.err};
  assign steps_v[0] = bus0.steps;
  assign steps_v[1] = bus1.steps;
  assign steps_v[2] = bus2.steps;

  count_seek_ctrl #(.WIDTH(4), .MAX_STEPS(15), .SHORTEST(0), .SW(4)) dut0 (
    .clk(clk), .reset(rst_n), .cmd(bus0.slave), .cnt(cnt_v[0]),
    .count_up(up_v[0]), .count_down(dn_v[0]));
  count_seek_ctrl #(.WIDTH(4), .MAX_STEPS(15), .SHORTEST(1), .SW(4)) dut1 (
    .clk(clk), .reset(rst_n), .cmd(bus1.slave), .cnt(cnt_v[1]),
    .count_up(up_v[1]), .count_down(dn_v[1]));
  count_seek_ctrl #(.WIDTH(4), .MAX_STEPS(4), .SHORTEST(0), .SW(4)) dut2 (
    .clk(clk), .reset(rst_n), .cmd(bus2.slave), .cnt(cnt_v[2]),
    .count_up(up_v[2]), .count_down(dn_v[2]));

  // Wrapping up/down counter models, one per DUT, with a bench preset.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (load)         cnt_v[k] <= load_val;
      else if (up_v[k]) cnt_v[k] <= cnt_v[k] + 4'd1;
      else if (dn_v[k]) cnt_v[k] <= cnt_v[k] - 4'd1;
    end
  end

  function automatic exp_t predict(int k, int unsigned c0, int unsigned t);
    exp_t e;
    int unsigned n;
    bit up;
    up = 1'b0;
    n  = 0;
    if (c0 != t) begin
      if (SH[k] != 0) up = (((t + 16 - c0) % 16) <= 8);
      else            up = (t > c0);
      n = up ? (t + 16 - c0) % 16 : (c0 + 16 - t) % 16;
    end
    if (n <= MX[k]) begin
      e.cnt = t;  e.steps = n;  e.err = 0;
    end else begin
      e.steps = MX[k];
      e.cnt   = up ? (c0 + MX[k]) % 16 : (c0 + 16 - MX[k]) % 16;
      e.err   = 1;
    end
    e.ups = up ? e.steps : 0;
    e.dns = up ? 0 : e.steps;
    e.lat = 2 * e.steps + 1;
    return e;
  endfunction

  // Scoreboard: pop an expectation whenever a DUT pulses done.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (up_v[k]) ups_n[k]++;
      if (dn_v[k]) dns_n[k]++;
      if (up_v[k] && dn_v[k]) both_n[k]++;
      if (done_v[k]) begin
        exp_t e;
        bit   ok;
        ok = 1'b0;
        case (k)
          0: if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
          1: if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
          default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
        compared++;
        if (!ok) begin
          mismatched++;
          $display("FAIL unexpected_done dut%0d: got done=1 required no done", k);
        end else begin
          compared += 8;
          if (32'(cnt_v[k]) !== e.cnt) begin mismatched++;
            $display("FAIL cnt dut%0d: got %0d required %0d", k, cnt_v[k], e.cnt); end
          if (32'(steps_v[k]) !== e.steps) begin mismatched++;
            $display("FAIL steps dut%0d: got %0d required %0d", k, steps_v[k], e.steps); end
          if (32'(err_v[k]) !== e.err) begin mismatched++;
            $display("FAIL err dut%0d: got %0d required %0d", k, err_v[k], e.err); end
          if (ups_n[k] !== e.ups) begin mismatched++;
            $display("FAIL up_pulses dut%0d: got %0d required %0d", k, ups_n[k], e.ups); end
          if (dns_n[k] !== e.dns) begin mismatched++;
            $display("FAIL down_pulses dut%0d: got %0d required %0d", k, dns_n[k], e.dns); end
          if (edge_n - start_edge !== e.lat) begin mismatched++;
            $display("FAIL latency dut%0d: got %0d required %0d", k, edge_n - start_edge, e.lat); end
          if (both_n[k] !== 0) begin mismatched++;
            $display("FAIL up_and_down dut%0d: got %0d cycles required 0", k, both_n[k]); end
          if (busy_v[k] !== 1'b0) begin mismatched++;
            $display("FAIL busy_at_done dut%0d: got %b required 0", k, busy_v[k]); end
        end
      end
    end
  end

  task automatic kick(input int unsigned c0, input int unsigned t, input bit push);
    @(posedge clk); #1 load = 1'b1; load_val = 4'(c0);
    @(posedge clk); #1 load = 1'b0;
    if (push) begin
      q0.push_back(predict(0, c0, t));
      q1.push_back(predict(1, c0, t));
      q2.push_back(predict(2, c0, t));
    end
    for (int k = 0; k < 3; k++) begin ups_n[k] = 0; dns_n[k] = 0; both_n[k] = 0; end
    target = 4'(t);
    start = 1'b1;
    start_edge = edge_n + 1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy_v == 3'b000 && done_v == 3'b000) break;
    end
    compared += 2;
    if (busy_v !== 3'b000) begin mismatched++;
      $display("FAIL %s_timeout: got busy=%b required 000", name, busy_v); end
    if (q0.size() + q1.size() + q2.size() != 0) begin mismatched++;
      $display("FAIL %s_missing_done: got %0d pending required 0", name,
               q0.size() + q1.size() + q2.size()); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; target = '0;
    load = 1'b1; load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    compared += 5;
    if (busy_v !== 3'b000) begin mismatched++; $display("FAIL reset_busy: got %b required 000", busy_v); end
    if (done_v !== 3'b000) begin mismatched++; $display("FAIL reset_done: got %b required 000", done_v); end
    if (err_v  !== 3'b000) begin mismatched++; $display("FAIL reset_err: got %b required 000", err_v); end
    if ((up_v | dn_v) !== 3'b000) begin mismatched++;
      $display("FAIL reset_pulses: got up=%b down=%b required 000", up_v, dn_v); end
    if ({steps_v[0], steps_v[1], steps_v[2]} !== 12'h000) begin mismatched++;
      $display("FAIL reset_steps: got %0d/%0d/%0d required 0", steps_v[0], steps_v[1], steps_v[2]); end
    @(negedge clk) rst_n = 1'b1;
    load = 1'b0;
  endtask

  task automatic test_seeks;
    kick(0, 5, 1);   wait_idle("up_0_5");
    kick(9, 3, 1);   wait_idle("down_9_3");
    kick(14, 1, 1);  wait_idle("wrap_14_1");
    kick(7, 7, 1);   wait_idle("equal_7");
    kick(0, 8, 1);   wait_idle("tie_0_8");
    kick(15, 0, 1);  wait_idle("wrap_15_0");
  endtask

  task automatic test_step_limit;
    kick(0, 10, 1);  wait_idle("limit_0_10");
    repeat (3) @(negedge clk);
    compared++;
    if (err_v !== 3'b100) begin mismatched++;
      $display("FAIL err_held: got %b required 100", err_v); end
    kick(3, 5, 1);   wait_idle("clear_3_5");
    compared++;
    if (err_v !== 3'b000) begin mismatched++;
      $display("FAIL err_cleared: got %b required 000", err_v); end
  endtask

  task automatic test_abort;
    kick(0, 5, 0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (4) @(negedge clk);
    compared += 3;
    if (busy_v !== 3'b000) begin mismatched++; $display("FAIL abort_busy: got %b required 000", busy_v); end
    for (int k = 0; k < 3; k++) begin
      if (cnt_v[k] !== 4'd2 || steps_v[k] !== 4'd2) begin mismatched++;
        $display("FAIL abort_state dut%0d: got cnt=%0d steps=%0d required 2/2", k, cnt_v[k], steps_v[k]); end
    end
    if (err_v !== 3'b000) begin mismatched++; $display("FAIL abort_err: got %b required 000", err_v); end
  endtask

  task automatic test_reset_mid_step;
    kick(0, 5, 0);
    @(posedge clk); #1;
    compared++;
    if (up_v !== 3'b111) begin mismatched++; $display("FAIL step_pulse: got %b required 111", up_v); end
    #2 rst_n = 1'b0;
    #1;
    compared += 3;
    if (up_v !== 3'b000) begin mismatched++; $display("FAIL reset_drop_up: got %b required 000", up_v); end
    if (busy_v !== 3'b000) begin mismatched++; $display("FAIL reset_mid_busy: got %b required 000", busy_v); end
    if ({steps_v[0], steps_v[1], steps_v[2]} !== 12'h000) begin mismatched++;
      $display("FAIL reset_mid_steps: got %0d/%0d/%0d required 0", steps_v[0], steps_v[1], steps_v[2]); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    kick(0, 5, 1);
    repeat (2) @(posedge clk);
    #1 target = 4'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("start_while_busy");
    compared++;
    if (cnt_v[0] !== 4'd5) begin mismatched++;
      $display("FAIL target_unchanged: got %0d required 5", cnt_v[0]); end
    kick(5, 2, 1);  wait_idle("b2b_5_2");
  endtask

  initial begin
    test_reset;
    test_seeks;
    test_step_limit;
    test_abort;
    test_reset_mid_step;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
